// File: rtl/sgdma_ingress.sv
// sgdma_ingress: splits input-port packets into linked shared-buffer
// cells and pushes one descriptor per stored packet.
module sgdma_ingress #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_PORTS  = 4,
  parameter int CELL_WORDS = 8,
  localparam int CW_BITS   = $clog2(CELL_WORDS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  output logic                          o_rd_en,
  input  logic [DATA_WIDTH-1:0]         i_dat,
  input  logic                          i_empty,
  output logic                          o_fp_rd_en,
  input  logic [ADDR_WIDTH-1:0]         i_fp_ptr,
  input  logic [ADDR_WIDTH:0]           i_fp_count,
  output logic                          o_mmu_wr_req,
  input  logic                          i_mmu_wr_ready,
  output logic [ADDR_WIDTH+CW_BITS-1:0] o_mmu_wr_addr,
  output logic [DATA_WIDTH-1:0]         o_mmu_wr_dat,
  output logic                          o_link_we,
  output logic [ADDR_WIDTH-1:0]         o_link_addr,
  output logic [ADDR_WIDTH-1:0]         o_link_dat,
  output logic [NUM_PORTS-1:0]          o_desc_wr_en,
  output logic [14+ADDR_WIDTH-1:0]      o_desc_dat,
  input  logic [NUM_PORTS-1:0]          i_desc_full,
  output logic [15:0]                   o_pkt_cnt,
  output logic [15:0]                   o_drop_cnt,
  output logic                          o_busy
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR   = 4'd1;
  localparam logic [3:0] S_DROP  = 4'd2;
  localparam logic [3:0] S_ALLOC = 4'd3;
  localparam logic [3:0] S_PTR   = 4'd4;
  localparam logic [3:0] S_DRD   = 4'd5;
  localparam logic [3:0] S_DCAP  = 4'd6;
  localparam logic [3:0] S_DWR   = 4'd7;
  localparam logic [3:0] S_DESC  = 4'd8;

  logic [3:0]            state;
  logic [10:0]           len_q;
  logic [10:0]           rem;
  logic [2:0]            prio_q;
  logic [3:0]            dest_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] head_q;
  logic [CW_BITS-1:0]    idx;
  logic                  first;

  logic [10:0] h_len;
  logic [2:0]  h_prio;
  logic [3:0]  h_dest;
  logic [11:0] cells;
  logic        full_hit;
  logic        drop;

  assign h_len  = i_dat[17:7];
  assign h_prio = i_dat[6:4];
  assign h_dest = i_dat[3:0];
  assign cells  = ({1'b0, h_len} + 12'(CELL_WORDS - 1)) >> CW_BITS;

  always_comb begin
    full_hit = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (32'(h_dest) == p) full_hit = i_desc_full[p];
  end

  // Whole-packet admission: nothing else consumes pointers or queue slots.
  assign drop = (h_len == '0)
             || (32'(h_dest) >= NUM_PORTS)
             || (32'(i_fp_count) < 32'(cells))
             || full_hit;

  assign o_rd_en = i_rst_n && !i_empty &&
    (state == S_IDLE || state == S_DRD ||
     (state == S_DROP && rem != '0));
  assign o_fp_rd_en = (state == S_ALLOC);
  assign o_busy     = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      len_q         <= '0;
      rem           <= '0;
      prio_q        <= '0;
      dest_q        <= '0;
      ptr_q         <= '0;
      head_q        <= '0;
      idx           <= '0;
      first         <= 1'b0;
      o_mmu_wr_req  <= 1'b0;
      o_mmu_wr_addr <= '0;
      o_mmu_wr_dat  <= '0;
      o_link_we     <= 1'b0;
      o_link_addr   <= '0;
      o_link_dat    <= '0;
      o_desc_wr_en  <= '0;
      o_desc_dat    <= '0;
      o_pkt_cnt     <= '0;
      o_drop_cnt    <= '0;
    end else begin
      o_link_we    <= 1'b0;
      o_desc_wr_en <= '0;
      unique case (state)
        S_IDLE: if (!i_empty) state <= S_HDR;
        S_HDR: begin
          len_q  <= h_len;
          rem    <= h_len;
          prio_q <= h_prio;
          dest_q <= h_dest;
          first  <= 1'b1;
          state  <= drop ? S_DROP : S_ALLOC;
        end
        S_DROP: begin
          if (rem == '0) begin
            if (o_drop_cnt != 16'hFFFF)
              o_drop_cnt <= o_drop_cnt + 16'd1;
            state <= S_IDLE;
          end else if (!i_empty) begin
            rem <= rem - 11'd1;
          end
        end
        S_ALLOC: state <= S_PTR;
        S_PTR: begin
          ptr_q <= i_fp_ptr;
          if (first) begin
            head_q <= i_fp_ptr;
          end else begin
            o_link_we   <= 1'b1;
            o_link_addr <= ptr_q;
            o_link_dat  <= i_fp_ptr;
          end
          first <= 1'b0;
          idx   <= '0;
          state <= S_DRD;
        end
        S_DRD: if (!i_empty) state <= S_DCAP;
        S_DCAP: begin
          o_mmu_wr_req  <= 1'b1;
          o_mmu_wr_addr <= {ptr_q, idx};
          o_mmu_wr_dat  <= i_dat;
          state         <= S_DWR;
        end
        S_DWR: begin
          if (i_mmu_wr_ready) begin
            o_mmu_wr_req <= 1'b0;
            rem          <= rem - 11'd1;
            idx          <= idx + CW_BITS'(1);
            if (rem == 11'd1) begin
              o_desc_wr_en <= NUM_PORTS'(1) << dest_q;
              o_desc_dat   <= {prio_q, len_q, head_q};
              state        <= S_DESC;
            end else if (&idx) begin
              state <= S_ALLOC;
            end else begin
              state <= S_DRD;
            end
          end
        end
        S_DESC: begin
          if (o_pkt_cnt != 16'hFFFF)
            o_pkt_cnt <= o_pkt_cnt + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgdma_ingress.sv
// tb_sgdma_ingress: directed scenarios against FIFO, free-list,
// MMU, link-table and descriptor-queue models.
module tb_sgdma_ingress;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        o_rd_en;
  logic [31:0] i_dat = '0;
  logic        i_empty;
  logic        o_fp_rd_en;
  logic [9:0]  i_fp_ptr = '0;
  logic [10:0] i_fp_count = 11'd64;
  logic        o_mmu_wr_req;
  logic        i_mmu_wr_ready = 1'b1;
  logic [12:0] o_mmu_wr_addr;
  logic [31:0] o_mmu_wr_dat;
  logic        o_link_we;
  logic [9:0]  o_link_addr;
  logic [9:0]  o_link_dat;
  logic [3:0]  o_desc_wr_en;
  logic [23:0] o_desc_dat;
  logic [3:0]  i_desc_full = '0;
  logic [15:0] o_pkt_cnt;
  logic [15:0] o_drop_cnt;
  logic        o_busy;

  sgdma_ingress #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10),
    .NUM_PORTS(4), .CELL_WORDS(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_rd_en(o_rd_en), .i_dat(i_dat), .i_empty(i_empty),
    .o_fp_rd_en(o_fp_rd_en), .i_fp_ptr(i_fp_ptr),
    .i_fp_count(i_fp_count),
    .o_mmu_wr_req(o_mmu_wr_req), .i_mmu_wr_ready(i_mmu_wr_ready),
    .o_mmu_wr_addr(o_mmu_wr_addr), .o_mmu_wr_dat(o_mmu_wr_dat),
    .o_link_we(o_link_we), .o_link_addr(o_link_addr),
    .o_link_dat(o_link_dat),
    .o_desc_wr_en(o_desc_wr_en), .o_desc_dat(o_desc_dat),
    .i_desc_full(i_desc_full),
    .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] fmem [0:1023];
  logic [9:0]  fpmem [0:255];
  int push_cnt = 0, pop_cnt = 0;
  int fp_push = 0, fp_pop = 0;
  logic stall_empty = 1'b0;
  logic force_ne = 1'b0;
  logic fifo_empty;

  assign fifo_empty = (push_cnt == pop_cnt);
  assign i_empty = (fifo_empty && !force_ne) || stall_empty;

  logic [12:0] acc_addr [0:255];
  logic [31:0] acc_dat  [0:255];
  int          acc_cyc  [0:255];
  logic [9:0]  lnk_a    [0:63];
  logic [9:0]  lnk_d    [0:63];
  logic [3:0]  d_en     [0:63];
  logic [23:0] d_dat    [0:63];
  int          d_cyc    [0:63];
  int acc_n = 0, lnk_n = 0, d_n = 0, cyc = 0;
  int rd_empty_err = 0, stab_err = 0;
  logic        pend = 1'b0;
  logic [12:0] p_addr = '0;
  logic [31:0] p_dat = '0;

  // Models of FIFO, free list and sinks; a reset flushes both sources.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pop_cnt <= push_cnt;
      fp_pop  <= fp_push;
      pend    <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (o_rd_en) begin
        if (fifo_empty) rd_empty_err <= rd_empty_err + 1;
        i_dat   <= fmem[pop_cnt % 1024];
        pop_cnt <= pop_cnt + 1;
      end
      if (o_fp_rd_en) begin
        i_fp_ptr <= fpmem[fp_pop % 256];
        fp_pop   <= fp_pop + 1;
      end
      if (o_mmu_wr_req && i_mmu_wr_ready) begin
        acc_addr[acc_n % 256] <= o_mmu_wr_addr;
        acc_dat[acc_n % 256]  <= o_mmu_wr_dat;
        acc_cyc[acc_n % 256]  <= cyc + 1;
        acc_n <= acc_n + 1;
      end
      if (o_link_we) begin
        lnk_a[lnk_n % 64] <= o_link_addr;
        lnk_d[lnk_n % 64] <= o_link_dat;
        lnk_n <= lnk_n + 1;
      end
      if (o_desc_wr_en != '0) begin
        d_en[d_n % 64]  <= o_desc_wr_en;
        d_dat[d_n % 64] <= o_desc_dat;
        d_cyc[d_n % 64] <= cyc + 1;
        d_n <= d_n + 1;
      end
      if (pend && (!o_mmu_wr_req || o_mmu_wr_addr != p_addr ||
                   o_mmu_wr_dat != p_dat))
        stab_err <= stab_err + 1;
      pend   <= o_mmu_wr_req && !i_mmu_wr_ready;
      p_addr <= o_mmu_wr_addr;
      p_dat  <= o_mmu_wr_dat;
    end
  end

  function automatic logic [31:0] hdr(input int len, input int prio,
                                      input int dest);
    return {14'd0, 11'(len), 3'(prio), 4'(dest)};
  endfunction

  task automatic push_word(input logic [31:0] w);
    fmem[push_cnt % 1024] = w;
    push_cnt++;
  endtask

  task automatic push_ptr(input logic [9:0] p);
    fpmem[fp_push % 256] = p;
    fp_push++;
  endtask

  task automatic push_pkt(input int len, input int prio, input int dest,
                          input logic [31:0] base, input int nw);
    push_word(hdr(len, prio, dest));
    for (int i = 0; i < nw; i++) push_word(base + 32'(i));
  endtask

  task automatic wait_done(input int budget, output bit ok);
    bit seen;
    seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (o_busy) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    force_ne = 1'b1;
    #3;
    checks++;
    if ({o_rd_en, o_fp_rd_en, o_mmu_wr_req, o_link_we,
         o_desc_wr_en, o_busy} !== '0) begin
      failures++;
      $display("FAIL reset_strobes got %b want 0", {o_rd_en, o_fp_rd_en,
        o_mmu_wr_req, o_link_we, o_desc_wr_en, o_busy});
    end
    checks++;
    if ({o_mmu_wr_addr, o_mmu_wr_dat, o_link_addr, o_link_dat,
         o_desc_dat, o_pkt_cnt, o_drop_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_data pkt=%h drop=%h addr=%h want 0",
               o_pkt_cnt, o_drop_cnt, o_mmu_wr_addr);
    end
    force_ne = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b rd=%b want 0 0", o_busy, o_rd_en);
    end
  endtask

  task automatic test_single();
    bit ok;
    int ab, db, lb, bad;
    ab = acc_n; db = d_n; lb = lnk_n;
    push_ptr(10'h010);
    push_pkt(8, 5, 2, 32'hA000, 8);
    wait_done(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_done timeout"); end
    checks++;
    if (acc_n - ab != 8) begin
      failures++;
      $display("FAIL single_count got %0d want 8", acc_n - ab);
    end
    bad = 0;
    for (int i = 0; i < 8 && i < acc_n - ab; i++)
      if (acc_addr[ab+i] !== 13'(32'h080 + i) ||
          acc_dat[ab+i] !== 32'hA000 + 32'(i)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL single_words bad=%0d want 0", bad);
    end
    checks++;
    if (lnk_n != lb) begin
      failures++;
      $display("FAIL single_link got %0d writes want 0", lnk_n - lb);
    end
    checks++;
    if (d_n - db != 1 || d_en[db] !== 4'b0100 ||
        d_dat[db] !== {3'd5, 11'd8, 10'h010}) begin
      failures++;
      $display("FAIL single_desc n=%0d en=%b dat=%h want 1 0100 %h",
               d_n - db, d_en[db], d_dat[db], {3'd5, 11'd8, 10'h010});
    end
    checks++;
    if (d_cyc[db] != acc_cyc[ab+7] + 1) begin
      failures++;
      $display("FAIL single_desc_lat got %0d want %0d",
               d_cyc[db], acc_cyc[ab+7] + 1);
    end
    checks++;
    if (o_pkt_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_pkt_cnt got %0d want 1", o_pkt_cnt);
    end
  endtask

  task automatic test_multi();
    bit ok;
    int ab, db, lb, fb, bad, e;
    ab = acc_n; db = d_n; lb = lnk_n; fb = fp_pop;
    push_ptr(10'h021); push_ptr(10'h022); push_ptr(10'h023);
    push_pkt(20, 3, 0, 32'hB000, 20);
    wait_done(500, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL multi_done timeout"); end
    checks++;
    if (acc_n - ab != 20) begin
      failures++;
      $display("FAIL multi_count got %0d want 20", acc_n - ab);
    end
    bad = 0;
    for (int i = 0; i < 20 && i < acc_n - ab; i++) begin
      e = (33 + i / 8) * 8 + i % 8;
      if (acc_addr[ab+i] !== 13'(e) ||
          acc_dat[ab+i] !== 32'hB000 + 32'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL multi_words bad=%0d want 0", bad);
    end
    checks++;
    if (acc_addr[ab+19] !== 13'h11B) begin
      failures++;
      $display("FAIL multi_last got %h want 11b", acc_addr[ab+19]);
    end
    checks++;
    if (lnk_n - lb != 2 || lnk_a[lb] !== 10'h021 ||
        lnk_d[lb] !== 10'h022 || lnk_a[lb+1] !== 10'h022 ||
        lnk_d[lb+1] !== 10'h023) begin
      failures++;
      $display("FAIL multi_links n=%0d got %h>%h %h>%h want 021>022 022>023",
               lnk_n - lb, lnk_a[lb], lnk_d[lb], lnk_a[lb+1], lnk_d[lb+1]);
    end
    checks++;
    if (fp_pop - fb != 3) begin
      failures++;
      $display("FAIL multi_fp_pops got %0d want 3", fp_pop - fb);
    end
    checks++;
    if (d_n - db != 1 || d_en[db] !== 4'b0001 ||
        d_dat[db] !== {3'd3, 11'd20, 10'h021}) begin
      failures++;
      $display("FAIL multi_desc en=%b dat=%h want 0001 %h",
               d_en[db], d_dat[db], {3'd3, 11'd20, 10'h021});
    end
  endtask

  task automatic test_bad_dest();
    bit ok;
    int ab, db, lb, fb, pb;
    ab = acc_n; db = d_n; lb = lnk_n; fb = fp_pop; pb = pop_cnt;
    push_pkt(6, 1, 5, 32'hC000, 6);
    wait_done(200, ok);
    checks++;
    if (!ok || pop_cnt - pb != 7) begin
      failures++;
      $display("FAIL bad_dest_pops ok=%0d got %0d want 7", ok, pop_cnt - pb);
    end
    checks++;
    if (acc_n != ab || lnk_n != lb || fp_pop != fb || d_n != db) begin
      failures++;
      $display("FAIL bad_dest_quiet acc=%0d lnk=%0d fp=%0d desc=%0d want 0",
               acc_n - ab, lnk_n - lb, fp_pop - fb, d_n - db);
    end
    checks++;
    if (o_drop_cnt !== 16'd1) begin
      failures++;
      $display("FAIL bad_dest_drop_cnt got %0d want 1", o_drop_cnt);
    end
    ab = acc_n; db = d_n;
    push_ptr(10'h030);
    push_pkt(3, 7, 3, 32'hD000, 3);
    wait_done(200, ok);
    checks++;
    if (!ok || acc_n - ab != 3 || acc_addr[ab] !== 13'h180 ||
        acc_addr[ab+2] !== 13'h182 || acc_dat[ab+2] !== 32'hD002) begin
      failures++;
      $display("FAIL after_drop_words n=%0d a0=%h a2=%h d2=%h want 3 180 182 d002",
               acc_n - ab, acc_addr[ab], acc_addr[ab+2], acc_dat[ab+2]);
    end
    checks++;
    if (d_n - db != 1 || d_en[db] !== 4'b1000 ||
        d_dat[db] !== {3'd7, 11'd3, 10'h030} || o_pkt_cnt !== 16'd3) begin
      failures++;
      $display("FAIL after_drop_desc en=%b dat=%h pkt=%0d want 1000 %h 3",
               d_en[db], d_dat[db], o_pkt_cnt, {3'd7, 11'd3, 10'h030});
    end
  endtask

  task automatic test_admission();
    bit ok;
    int ab, db, fb, pb;
    ab = acc_n; db = d_n; fb = fp_pop; pb = pop_cnt;
    i_fp_count = 11'd1;
    push_pkt(9, 2, 0, 32'hE000, 9);
    wait_done(200, ok);
    checks++;
    if (!ok || pop_cnt - pb != 10 || o_drop_cnt !== 16'd2) begin
      failures++;
      $display("FAIL adm_fp ok=%0d pops=%0d drop=%0d want 1 10 2",
               ok, pop_cnt - pb, o_drop_cnt);
    end
    checks++;
    if (acc_n != ab || fp_pop != fb || d_n != db) begin
      failures++;
      $display("FAIL adm_fp_quiet acc=%0d fp=%0d desc=%0d want 0",
               acc_n - ab, fp_pop - fb, d_n - db);
    end
    i_fp_count = 11'd64;
    i_desc_full = 4'b0010;
    pb = pop_cnt;
    push_pkt(4, 2, 1, 32'hE100, 4);
    wait_done(200, ok);
    checks++;
    if (!ok || pop_cnt - pb != 5 || o_drop_cnt !== 16'd3) begin
      failures++;
      $display("FAIL adm_full ok=%0d pops=%0d drop=%0d want 1 5 3",
               ok, pop_cnt - pb, o_drop_cnt);
    end
    checks++;
    if (acc_n != ab || fp_pop != fb || d_n != db ||
        o_pkt_cnt !== 16'd3) begin
      failures++;
      $display("FAIL adm_full_quiet acc=%0d fp=%0d desc=%0d pkt=%0d want 0 0 0 3",
               acc_n - ab, fp_pop - fb, d_n - db, o_pkt_cnt);
    end
    i_desc_full = 4'b0000;
  endtask

  task automatic test_backpressure();
    bit ok;
    int ab, db, pb, bad;
    ab = acc_n; db = d_n; pb = pop_cnt;
    push_ptr(10'h040);
    push_pkt(5, 4, 1, 32'hF000, 2);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge i_clk);
      ok = (acc_n - ab >= 2);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_first timeout"); end
    i_mmu_wr_ready = 1'b0;
    stall_empty = 1'b1;
    for (int i = 2; i < 5; i++) push_word(32'hF000 + 32'(i));
    bad = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_rd_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_rd_on_empty got %0d want 0", bad);
    end
    stall_empty = 1'b0;
    repeat (10) @(negedge i_clk);
    checks++;
    if (pop_cnt - pb != 4 || o_mmu_wr_req !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold pops=%0d req=%b want 4 1",
               pop_cnt - pb, o_mmu_wr_req);
    end
    i_mmu_wr_ready = 1'b1;
    wait_done(200, ok);
    checks++;
    if (!ok || stab_err != 0) begin
      failures++;
      $display("FAIL bp_stable ok=%0d err=%0d want 1 0", ok, stab_err);
    end
    bad = 0;
    for (int i = 0; i < 5 && i < acc_n - ab; i++)
      if (acc_addr[ab+i] !== 13'(32'h200 + i) ||
          acc_dat[ab+i] !== 32'hF000 + 32'(i)) bad++;
    checks++;
    if (acc_n - ab != 5 || bad != 0 || pop_cnt - pb != 6) begin
      failures++;
      $display("FAIL bp_words n=%0d bad=%0d pops=%0d want 5 0 6",
               acc_n - ab, bad, pop_cnt - pb);
    end
    checks++;
    if (d_n - db != 1 || d_dat[db] !== {3'd4, 11'd5, 10'h040} ||
        o_pkt_cnt !== 16'd4) begin
      failures++;
      $display("FAIL bp_desc dat=%h pkt=%0d want %h 4",
               d_dat[db], o_pkt_cnt, {3'd4, 11'd5, 10'h040});
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int ab, db;
    ab = acc_n;
    push_ptr(10'h050);
    push_pkt(8, 6, 0, 32'h1000, 8);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge i_clk);
      ok = (acc_n - ab >= 3);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_mid_wait timeout"); end
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_rd_en, o_fp_rd_en, o_mmu_wr_req, o_link_we,
         o_desc_wr_en, o_busy} !== '0 ||
        {o_mmu_wr_addr, o_pkt_cnt, o_drop_cnt} !== '0) begin
      failures++;
      $display("FAIL rst_mid_async busy=%b req=%b pkt=%0d drop=%0d want 0",
               o_busy, o_mmu_wr_req, o_pkt_cnt, o_drop_cnt);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    ab = acc_n; db = d_n;
    push_ptr(10'h060);
    push_pkt(2, 1, 2, 32'h2000, 2);
    wait_done(200, ok);
    checks++;
    if (!ok || acc_n - ab != 2 || acc_addr[ab] !== 13'h300 ||
        acc_addr[ab+1] !== 13'h301 || acc_dat[ab+1] !== 32'h2001) begin
      failures++;
      $display("FAIL rst_mid_new n=%0d a0=%h a1=%h want 2 300 301",
               acc_n - ab, acc_addr[ab], acc_addr[ab+1]);
    end
    checks++;
    if (d_n - db != 1 || d_dat[db] !== {3'd1, 11'd2, 10'h060} ||
        o_pkt_cnt !== 16'd1 || o_drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_mid_cnt dat=%h pkt=%0d drop=%0d want %h 1 0",
               d_dat[db], o_pkt_cnt, o_drop_cnt, {3'd1, 11'd2, 10'h060});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_bad_dest();
    test_admission();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (rd_empty_err != 0) begin
      failures++;
      $display("FAIL rd_on_empty got %0d want 0", rd_empty_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sgdma_ingress.md
# sgdma_ingress

Parametrised ingress scatter-gather DMA for one switch input port. It drains packets from the port's input FIFO and splits each one into fixed-size cells. Cells are stored in the shared buffer through the MMU write handshake using pointers from the free-pointer list, and the cells are chained in the link table. A completed packet produces one descriptor pushed into the destination port's crossbar queue. Packets that cannot be fully admitted are discarded whole; no partial packets ever reach the shared buffer.

## Interface
- DATA_WIDTH, 32: input word and MMU data width (≥18).
- ADDR_WIDTH, 10: cell pointer width.
- NUM_PORTS, 4: destination queues (1..16).
- CELL_WORDS, 8: words per cell (power of two, ≥2); CW_BITS = log2(CELL_WORDS).
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- o_rd_en  out  1  input FIFO read; i_dat valid the cycle after.
- i_dat  in  DATA_WIDTH  FIFO data.
  - Header bits [17:7]: length in words.
  - Header bits [6:4]: priority.
  - Header bits [3:0]: dest port.
- i_empty  in  1  FIFO empty.
- o_fp_rd_en  out  1  free-pointer pop; i_fp_ptr valid the cycle after.
- i_fp_ptr  in  ADDR_WIDTH  popped pointer.
- i_fp_count  in  ADDR_WIDTH+1  pointers available.
- o_mmu_wr_req  out  1  write request.
- i_mmu_wr_ready  in  1  write accept.
- o_mmu_wr_addr  out  ADDR_WIDTH+CW_BITS  word address {ptr, word index}.
- o_mmu_wr_dat  out  DATA_WIDTH  word data.
- o_link_we  out  1  link-table write pulse.
- o_link_addr  out  ADDR_WIDTH  previous cell pointer.
- o_link_dat  out  ADDR_WIDTH  next cell pointer.
- o_desc_wr_en  out  NUM_PORTS  one-hot descriptor push.
- o_desc_dat  out  14+ADDR_WIDTH  {priority[2:0], length[10:0], head ptr}.
- i_desc_full  in  NUM_PORTS  per-queue full.
- o_pkt_cnt  out  16  packets stored, saturating.
- o_drop_cnt  out  16  packets dropped, saturating.
- o_busy  out  1  state ≠ IDLE.

## Operation
- Cell count: cells = ceil(len / CELL_WORDS), i.e. (len + CELL_WORDS−1) >> CW_BITS, computed at 12 bits.
- IDLE: when !i_empty, pulse o_rd_en and go to HDR.
- HDR: capture header. Drop if any of:
  - len == 0;
  - dest ≥ NUM_PORTS;
  - i_fp_count < cells;
  - i_desc_full[dest].
  - Dropping → DROP. Otherwise → ALLOC.
  - Admission is decided here only. This block is the sole writer of both the free list and the queues, so the conditions cannot worsen mid-packet.
- ALLOC: pulse o_fp_rd_en, go to PTR.
- PTR: capture i_fp_ptr.
  - First cell: also latch it as the head pointer.
  - Later cells: pulse o_link_we with addr = previous ptr, dat = new ptr.
  - Reset the word index to 0, then go to DRD.
- DRD: when !i_empty, pulse o_rd_en, go to DCAP.
- DCAP: load o_mmu_wr_addr = {ptr, idx} and o_mmu_wr_dat = i_dat, assert o_mmu_wr_req, go to DWR.
- DWR: hold req, addr and dat stable until req & ready. On accept:
  - deassert req;
  - decrement words-remaining and increment idx;
  - remaining == 0 → DESC; idx wrapped to 0 → ALLOC; else → DRD.
- DESC: one-cycle o_desc_wr_en[dest] pulse with o_desc_dat; increment o_pkt_cnt; go to IDLE.
- DROP: pop len words from the FIFO (one per cycle while !i_empty) without any MMU, link or pointer activity. After the last word, increment o_drop_cnt and go to IDLE. If len == 0, nothing is popped.
- The tail cell's link entry is never written; consumers rely on length.
- In a partial last cell, only the valid words are written.

## Timing
- Reset: every output is 0, the counters are 0, and state is IDLE.
  - Asserting reset mid-packet abandons the packet immediately.
  - Popped pointers are not returned.
- Header latency: o_rd_en, then the header is captured next cycle, then o_fp_rd_en the cycle after.
- Per word: minimum 3 cycles (DRD, DCAP, DWR with ready high). An empty FIFO or low ready stalls without limit.
- Per cell: +2 cycles (ALLOC, PTR).
- Descriptor: exactly 1 cycle after the final MMU accept.
- o_rd_en and o_fp_rd_en are never asserted while their FIFO is empty. They are never high for two consecutive cycles in store mode.
- o_mmu_wr_req is never asserted while a previous request is pending. o_link_we and o_desc_wr_en are single-cycle pulses.
- Counters hold at 0xFFFF.

## Test plan
- **Single-cell packet.** Header len=8, dest=2, prio=5; free ptr 0x010.
  - Expect 8 accepts at addresses 0x080–0x087 with data equal to the payload in order.
  - Expect no o_link_we.
  - Expect o_desc_wr_en=4'b0100 with desc {5, 8, 0x010}, and o_pkt_cnt=1.
- **Multi-cell packet.** len=20, ptrs 0x021, 0x022, 0x023.
  - Expect link writes 0x021→0x022 and 0x022→0x023.
  - Expect the last cell written at 0x118–0x11B only, and desc length 20 with head 0x021.
- **Bad destination.** dest=5, len=6.
  - Expect 6 words popped, zero MMU, link and fp activity, and o_drop_cnt=1.
  - A following valid packet is stored correctly.
- **Admission drops.**
  - i_fp_count=1 with len=9: dropped.
  - i_desc_full[1]=1 with dest=1: dropped.
  - In both cases the counters and outputs behave as in the bad-destination case.
- **Backpressure.** i_mmu_wr_ready low for 10 cycles mid-packet and i_empty pulsed high between words.
  - Expect req, addr and dat stable throughout, no extra pops, and the packet intact.
- **Reset mid-packet.** Reset asserted after the 3rd accepted word.
  - All outputs are 0 asynchronously.
  - After release, a new packet stores from IDLE with the counters at 0.
